// File: rtl/sync_bits_filtered.sv
// Multi-bit synchroniser into out_clk with a per-bit stability filter.
// A new level is committed only after FILTER_LEN consecutive cycles; each commit emits one-cycle edge pulses.
module sync_bits_filtered #(
  parameter int                     NUM_OF_BITS   = 1,
  parameter int                     NUM_OF_STAGES = 2,
  parameter int                     FILTER_LEN    = 4,
  parameter logic [NUM_OF_BITS-1:0] RESET_VALUE   = '0
) (
  input  logic                   out_clk,
  input  logic                   out_reset,
  input  logic [NUM_OF_BITS-1:0] in_bits,
  output logic [NUM_OF_BITS-1:0] out_bits,
  output logic [NUM_OF_BITS-1:0] out_rise,
  output logic [NUM_OF_BITS-1:0] out_fall,
  output logic                   out_change
);

  localparam int               CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (NUM_OF_STAGES < 2) begin : g_bad_stages
      $error("sync_bits_filtered: NUM_OF_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
      $error("sync_bits_filtered: FILTER_LEN must be at least 1");
    end
  endgenerate

  // Metastability chain: tools must keep these flops adjacent and un-retimed.
  (* ASYNC_REG = "TRUE", shreg_extract = "no", dont_retime = "true" *)
  logic [NUM_OF_BITS-1:0] stage [NUM_OF_STAGES];

  logic [NUM_OF_BITS-1:0] sample;
  logic [CNT_W-1:0]       cnt      [NUM_OF_BITS];
  logic [CNT_W-1:0]       cnt_next [NUM_OF_BITS];
  logic [NUM_OF_BITS-1:0] bits_next;
  logic [NUM_OF_BITS-1:0] rise_next;
  logic [NUM_OF_BITS-1:0] fall_next;

  assign sample = stage[NUM_OF_STAGES-1];

  always_ff @(posedge out_clk) begin
    if (out_reset) begin
      for (int n = 0; n < NUM_OF_STAGES; n++) stage[n] <= RESET_VALUE;
    end else begin
      stage[0] <= in_bits;
      for (int n = 1; n < NUM_OF_STAGES; n++) stage[n] <= stage[n-1];
    end
  end

  // The counter holds how many cycles the sample has disagreed with the committed level.
  always_comb begin
    bits_next = out_bits;
    rise_next = '0;
    fall_next = '0;
    for (int i = 0; i < NUM_OF_BITS; i++) begin
      cnt_next[i] = '0;
      if (sample[i] != out_bits[i]) begin
        if (cnt[i] == CNT_MAX) begin
          bits_next[i] = sample[i];
          rise_next[i] = sample[i];
          fall_next[i] = ~sample[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge out_clk) begin
    if (out_reset) begin
      out_bits   <= RESET_VALUE;
      out_rise   <= '0;
      out_fall   <= '0;
      out_change <= 1'b0;
      for (int i = 0; i < NUM_OF_BITS; i++) cnt[i] <= '0;
    end else begin
      out_bits   <= bits_next;
      out_rise   <= rise_next;
      out_fall   <= fall_next;
      out_change <= |(rise_next | fall_next);
      for (int i = 0; i < NUM_OF_BITS; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule

// File: tb/tb_sync_bits_filtered.sv
// Directed bench for sync_bits_filtered: a default 4-bit instance and a
// 3-stage, unfiltered 1-bit instance, both on one clock.
module tb_sync_bits_filtered;

  logic       clk;
  logic       rst;
  logic [3:0] in_bits;
  logic [3:0] out_bits;
  logic [3:0] out_rise;
  logic [3:0] out_fall;
  logic       out_change;

  logic rst_f;
  logic in_f;
  logic out_f;
  logic rise_f;
  logic fall_f;
  logic change_f;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];

  sync_bits_filtered #(
    .NUM_OF_BITS  (4),
    .NUM_OF_STAGES(2),
    .FILTER_LEN   (4),
    .RESET_VALUE  (4'h0)
  ) u_dut (
    .out_clk   (clk),
    .out_reset (rst),
    .in_bits   (in_bits),
    .out_bits  (out_bits),
    .out_rise  (out_rise),
    .out_fall  (out_fall),
    .out_change(out_change)
  );

  sync_bits_filtered #(
    .NUM_OF_BITS  (1),
    .NUM_OF_STAGES(3),
    .FILTER_LEN   (1),
    .RESET_VALUE  (1'b0)
  ) u_fast (
    .out_clk   (clk),
    .out_reset (rst_f),
    .in_bits   (in_f),
    .out_bits  (out_f),
    .out_rise  (rise_f),
    .out_fall  (fall_f),
    .out_change(change_f)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic pat [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic       prev;
    logic [3:0] exp_v;

    rst     = 1'b1;
    in_bits = 4'hF;
    rst_f   = 1'b1;
    in_f    = 1'b0;

    // Reset with all inputs high: outputs must hold the reset value.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_bits", 32'(out_bits), 32'h0);
      check("rst_pulse", 32'({out_rise, out_fall, out_change}), 32'h0);
    end
    check("fast_rst", 32'({change_f, rise_f, fall_f, out_f}), 32'h0);
    rst   = 1'b0;
    rst_f = 1'b0;

    // Release: first edge after release is edge 1, commit at edge 6.
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("rel_bits", 32'(out_bits), (k >= 6) ? 32'hF : 32'h0);
      check("rel_rise", 32'(out_rise), (k == 6) ? 32'hF : 32'h0);
      check("rel_change", 32'(out_change), (k == 6) ? 32'h1 : 32'h0);
    end
    check("rel_fall", 32'(out_fall), 32'h0);

    // Back to all-low.
    in_bits = 4'h0;
    repeat (5) tick();
    check("low_hold", 32'(out_bits), 32'hF);
    tick();
    check("low_bits", 32'(out_bits), 32'h0);
    check("low_fall", 32'(out_fall), 32'hF);
    check("low_change", 32'(out_change), 32'h1);
    repeat (3) tick();

    // Glitch: bit0 high for 3 cycles is discarded.
    in_bits = 4'h1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) in_bits = 4'h0;
      check("glitch", 32'({out_bits, out_rise, out_fall, out_change}), 32'h0);
    end

    // Minimum pulse: bit0 high exactly 4 cycles.
    in_bits = 4'h1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) in_bits = 4'h0;
      check("minp_bits", 32'(out_bits), (k >= 6 && k <= 9) ? 32'h1 : 32'h0);
      check("minp_rise", 32'(out_rise), (k == 6) ? 32'h1 : 32'h0);
      check("minp_fall", 32'(out_fall), (k == 10) ? 32'h1 : 32'h0);
    end

    // Simultaneous transitions on two bits.
    in_bits = 4'h4;
    repeat (8) tick();
    check("simul_pre", 32'(out_bits), 32'h4);
    in_bits = 4'h2;
    repeat (5) tick();
    check("simul_wait", 32'({out_bits, out_change}), 32'h8);
    tick();
    check("simul_bits", 32'(out_bits), 32'h2);
    check("simul_rise", 32'(out_rise), 32'h2);
    check("simul_fall", 32'(out_fall), 32'h4);
    check("simul_change", 32'(out_change), 32'h1);
    tick();
    check("simul_clear", 32'({out_rise, out_fall, out_change}), 32'h0);

    // Reset mid-count on bit3.
    in_bits = 4'h0;
    repeat (8) tick();
    check("mid_pre", 32'(out_bits), 32'h0);
    in_bits = 4'h8;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mid_rst", 32'({out_bits, out_rise, out_change}), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("mid_bits", 32'(out_bits), (k == 6) ? 32'h8 : 32'h0);
      check("mid_rise", 32'(out_rise), (k == 6) ? 32'h8 : 32'h0);
    end

    // Fast instance: every level appears 4 edges after it is first sampled.
    prev = 1'b0;
    for (int j = 0; j < 12; j++) begin
      exp_v = {pat[j] ^ prev, pat[j] & ~prev, ~pat[j] & prev, pat[j]};
      exp_q.push_back(exp_v);
      prev = pat[j];
    end
    in_f = pat[0];
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t >= 4) begin
        if (exp_q.size() == 0) begin
          check("fast_q_empty", 32'(exp_q.size()), 32'h1);
        end else begin
          exp_v = exp_q.pop_front();
          check("fast", 32'({change_f, rise_f, fall_f, out_f}), 32'(exp_v));
        end
      end
      if (t < 12) in_f = pat[t];
    end
    check("fast_q_drained", 32'(exp_q.size()), 32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
